// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing a small word-addressed RAM between two requesters.
// Define RAM_ARB_STATS_EN to add saturating per-requester handshake counters.
module ram_port_arbiter #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0
   input  logic              req0_valid,
   input  logic              req0_rw,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rdata,
   // requester 1
   input  logic              req1_valid,
   input  logic              req1_rw,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rdata,
`ifdef RAM_ARB_STATS_EN
   output logic [7:0]        grant_cnt0,
   output logic [7:0]        grant_cnt1,
`endif
   // RAM side
   output logic              ram_en,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              grant0, grant1;
   logic              hs0, hs1, hs;

   logic              ram_en_q, ram_en_d;
   logic              ram_rw_q, ram_rw_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   logic              resp0_valid_q, resp0_valid_d;
   logic              resp1_valid_q, resp1_valid_d;
   logic [DATA_W-1:0] resp0_rdata_q, resp0_rdata_d;
   logic [DATA_W-1:0] resp1_rdata_q, resp1_rdata_d;

   // last_grant_q == 1 means requester 1 won last, so requester 0 wins a tie.
   always_comb begin : grant_logic
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & ~grant0;
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values of all the others.
   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // NOTE: each combinational block assigns a default to every variable it
   // drives before any branch, so no path can infer a latch.
   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant0 || grant1) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (ready is combinational and only offered in IDLE)
   // ------------------------------------------------------------------
   always_comb begin : fsm_outputs
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == IDLE) begin
         req0_ready = grant0;
         req1_ready = grant1;
      end
   end

   // A grant implies the matching valid, so ready alone marks the handshake.
   assign hs0 = req0_ready;
   assign hs1 = req1_ready;
   assign hs  = hs0 | hs1;

   // ------------------------------------------------------------------
   // Datapath next-state: RAM command, owner tracking, response capture
   // ------------------------------------------------------------------
   always_comb begin : datapath_next
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      ram_en_d      = 1'b0;
      ram_rw_d      = 1'b0;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      resp0_valid_d = 1'b0;
      resp1_valid_d = 1'b0;
      resp0_rdata_d = '0;
      resp1_rdata_d = '0;

      if (hs) begin
         owner_d      = hs1;
         last_grant_d = hs1;
         ram_en_d     = 1'b1;
         ram_rw_d     = hs1 ? req1_rw    : req0_rw;
         ram_addr_d   = hs1 ? req1_addr  : req0_addr;
         ram_wdata_d  = hs1 ? req1_wdata : req0_wdata;
      end

      // Read data is taken at the edge that closes the access cycle.
      if (state_q == ACCESS) begin
         if (owner_q) begin
            resp1_valid_d = 1'b1;
            resp1_rdata_d = ram_rw_q ? '0 : ram_rdata;
         end else begin
            resp0_valid_d = 1'b1;
            resp0_rdata_d = ram_rw_q ? '0 : ram_rdata;
         end
      end
   end

   // An asynchronous reset drops ram_en at once, so an in-flight write never
   // reaches its commit edge and its response is never issued.
   always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
      if (!rst_n) begin
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         ram_en_q      <= 1'b0;
         ram_rw_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         resp0_rdata_q <= '0;
         resp1_rdata_q <= '0;
      end else begin
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         ram_en_q      <= ram_en_d;
         ram_rw_q      <= ram_rw_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
         resp0_rdata_q <= resp0_rdata_d;
         resp1_rdata_q <= resp1_rdata_d;
      end
   end

   assign ram_en      = ram_en_q;
   assign ram_rw      = ram_rw_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign resp0_rdata = resp0_rdata_q;
   assign resp1_rdata = resp1_rdata_q;

`ifdef RAM_ARB_STATS_EN
   logic [7:0] grant_cnt0_q, grant_cnt0_d;
   logic [7:0] grant_cnt1_q, grant_cnt1_d;

   // Counters stick at 8'hFF rather than wrapping.
   always_comb begin : stats_next
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (hs0 && (grant_cnt0_q != 8'hFF)) grant_cnt0_d = grant_cnt0_q + 8'd1;
      if (hs1 && (grant_cnt1_q != 8'hFF)) grant_cnt1_d = grant_cnt1_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin : stats_reg
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 4x8 RAM model.
// Inputs change on the falling edge; outputs are checked away from the rising edge.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_rw, req0_ready, resp0_valid;
   logic [1:0] req0_addr;
   logic [7:0] req0_wdata, resp0_rdata;
   logic       req1_valid, req1_rw, req1_ready, resp1_valid;
   logic [1:0] req1_addr;
   logic [7:0] req1_wdata, resp1_rdata;
   logic       ram_en, ram_rw;
   logic [1:0] ram_addr;
   logic [7:0] ram_wdata, ram_rdata;
`ifdef RAM_ARB_STATS_EN
   logic [7:0] grant_cnt0, grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   // RAM model: combinational read, write on the rising edge while enabled.
   logic [7:0] mem [4] = '{8'h00, 8'h00, 8'h00, 8'h5C};
   assign ram_rdata = mem[ram_addr];
   always @(posedge clk) if (ram_en && ram_rw) mem[ram_addr] <= ram_wdata;

   always #5 clk = ~clk;

   ram_port_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_rw     (req0_rw),
      .req0_addr   (req0_addr),
      .req0_wdata  (req0_wdata),
      .req0_ready  (req0_ready),
      .resp0_valid (resp0_valid),
      .resp0_rdata (resp0_rdata),
      .req1_valid  (req1_valid),
      .req1_rw     (req1_rw),
      .req1_addr   (req1_addr),
      .req1_wdata  (req1_wdata),
      .req1_ready  (req1_ready),
      .resp1_valid (resp1_valid),
      .resp1_rdata (resp1_rdata),
`ifdef RAM_ARB_STATS_EN
      .grant_cnt0  (grant_cnt0),
      .grant_cnt1  (grant_cnt1),
`endif
      .ram_en      (ram_en),
      .ram_rw      (ram_rw),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = 2'd0; req0_wdata = 8'h00;
      req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = 2'd0; req1_wdata = 8'h00;

      // Reset state
      #1;
      check("rst_ram_en",    32'(ram_en),      32'd0);
      check("rst_ram_rw",    32'(ram_rw),      32'd0);
      check("rst_ram_addr",  32'(ram_addr),    32'd0);
      check("rst_ram_wdata", 32'(ram_wdata),   32'd0);
      check("rst_resp0_v",   32'(resp0_valid), 32'd0);
      check("rst_resp1_v",   32'(resp1_valid), 32'd0);
      check("rst_resp0_d",   32'(resp0_rdata), 32'd0);
      check("rst_resp1_d",   32'(resp1_rdata), 32'd0);
      check("rst_ready0",    32'(req0_ready),  32'd0);
      check("rst_ready1",    32'(req1_ready),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: req0 write addr 2 = 0xA5
      req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 2'd2; req0_wdata = 8'hA5;
      #1;
      check("t1_ready0", 32'(req0_ready), 32'd1);
      check("t1_ready1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req0_addr = 2'd0; req0_wdata = 8'h00;
      #1;
      check("t1_acc_en",    32'(ram_en),     32'd1);
      check("t1_acc_rw",    32'(ram_rw),     32'd1);
      check("t1_acc_addr",  32'(ram_addr),   32'd2);
      check("t1_acc_wdata", 32'(ram_wdata),  32'hA5);
      check("t1_acc_rdy0",  32'(req0_ready), 32'd0);
      @(negedge clk);
      check("t1_resp0_v",  32'(resp0_valid), 32'd1);
      check("t1_resp0_d",  32'(resp0_rdata), 32'd0);
      check("t1_resp1_v",  32'(resp1_valid), 32'd0);
      check("t1_resp_en",  32'(ram_en),      32'd0);
      check("t1_resp_rw",  32'(ram_rw),      32'd0);
      check("t1_hold_adr", 32'(ram_addr),    32'd2);
      check("t1_hold_wd",  32'(ram_wdata),   32'hA5);
      @(negedge clk);
      check("t1_idle_r0v", 32'(resp0_valid), 32'd0);

      // T2: req1 read addr 2 returns 0xA5
      req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 2'd2;
      #1;
      check("t2_ready1", 32'(req1_ready), 32'd1);
      check("t2_ready0", 32'(req0_ready), 32'd0);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      check("t2_acc_en",   32'(ram_en),   32'd1);
      check("t2_acc_rw",   32'(ram_rw),   32'd0);
      check("t2_acc_addr", 32'(ram_addr), 32'd2);
      @(negedge clk);
      check("t2_resp1_v", 32'(resp1_valid), 32'd1);
      check("t2_resp1_d", 32'(resp1_rdata), 32'hA5);
      check("t2_resp0_v", 32'(resp0_valid), 32'd0);
      check("t2_resp0_d", 32'(resp0_rdata), 32'd0);
      @(negedge clk);

      // T3: both valid from reset -> 0, 1, 0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 2'd0; req0_wdata = 8'h11;
      req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 2'd1; req1_wdata = 8'h22;
      #1;
      check("t3_c1_rdy0", 32'(req0_ready), 32'd1);
      check("t3_c1_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      req0_wdata = 8'h33;
      #1;
      check("t3_c1_wd",   32'(ram_wdata),  32'h11);
      check("t3_c1_adr",  32'(ram_addr),   32'd0);
      check("t3_acc_rd0", 32'(req0_ready), 32'd0);
      check("t3_acc_rd1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      check("t3_c1_resp0", 32'(resp0_valid), 32'd1);
      @(negedge clk);
      #1;
      check("t3_c2_rdy1", 32'(req1_ready), 32'd1);
      check("t3_c2_rdy0", 32'(req0_ready), 32'd0);
      @(negedge clk);
      check("t3_c2_adr", 32'(ram_addr),  32'd1);
      check("t3_c2_wd",  32'(ram_wdata), 32'h22);
      @(negedge clk);
      check("t3_c2_resp1", 32'(resp1_valid), 32'd1);
      check("t3_c2_resp0", 32'(resp0_valid), 32'd0);
      @(negedge clk);
      #1;
      check("t3_c3_rdy0", 32'(req0_ready), 32'd1);
      check("t3_c3_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("t3_c3_adr", 32'(ram_addr),  32'd0);
      check("t3_c3_wd",  32'(ram_wdata), 32'h33);
      @(negedge clk);
      @(negedge clk);

      // T4: req0 back-to-back reads of addr 0 (holds 0x33), req1 idle
      req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 2'd0;
      for (int c = 0; c < 12; c++) begin
         #1;
         check($sformatf("t4_rdy0_c%0d", c), 32'(req0_ready),  32'(c % 3 == 0));
         check($sformatf("t4_en_c%0d", c),   32'(ram_en),      32'(c % 3 == 1));
         check($sformatf("t4_rsp_c%0d", c),  32'(resp0_valid), 32'(c % 3 == 2));
         if (c % 3 == 2) check($sformatf("t4_rd_c%0d", c), 32'(resp0_rdata), 32'h33);
         if (c == 11) req0_valid = 1'b0;
         @(negedge clk);
      end

      // T5: reset during ACCESS of a write addr 3 = 0xFF
      req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 2'd3; req0_wdata = 8'hFF;
      #1;
      check("t5_rdy0", 32'(req0_ready), 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      check("t5_acc_en", 32'(ram_en), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_async_en", 32'(ram_en), 32'd0);
      check("t5_async_rw", 32'(ram_rw), 32'd0);
      @(negedge clk);
      check("t5_no_resp0", 32'(resp0_valid), 32'd0);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 2'd3;
      req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 2'd2;
      #1;
      check("t5_prio_rdy0", 32'(req0_ready), 32'd1);
      check("t5_prio_rdy1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("t5_rd_adr", 32'(ram_addr), 32'd3);
      check("t5_rd_rw",  32'(ram_rw),   32'd0);
      @(negedge clk);
      check("t5_resp0_v", 32'(resp0_valid), 32'd1);
      check("t5_resp0_d", 32'(resp0_rdata), 32'h5C);
      check("t5_resp1_v", 32'(resp1_valid), 32'd0);
      @(negedge clk);

`ifdef RAM_ARB_STATS_EN
      // T6: 300 req0 handshakes saturate grant_cnt0 at 255
      rst_n = 1'b0;
      #1;
      check("t6_rst_cnt0", 32'(grant_cnt0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 2'd0;
      repeat (900) @(negedge clk);
      req0_valid = 1'b0;
      check("t6_sat_cnt0", 32'(grant_cnt0), 32'd255);
      check("t6_cnt1",     32'(grant_cnt1), 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_clr_cnt0", 32'(grant_cnt0), 32'd0);
      check("t6_clr_cnt1", 32'(grant_cnt1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester controller that shares the 4-word x 8-bit RAM array between two masters.
- Arbitrates round-robin and accepts one transaction per grant with a valid/ready handshake.
- Drives the RAM's cell-select address, read/write, and write data, captures read data, and returns a response pulse to the winner.
- Sits between the two datapath masters and the RAM.

Parameters:
- ADDR_W, 2, word address width (4 words)
- DATA_W, 8, word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a transaction
- req0_rw  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  word address (bit0 -> s0, bit1 -> s1)
- req0_wdata  in  DATA_W  write data
- req0_ready  out  1  transaction accepted this cycle
- resp0_valid  out  1  one-cycle completion pulse
- resp0_rdata  out  DATA_W  read data; 0 for writes
- req1_valid, req1_rw, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_rdata: same as requester 0
- ram_en  out  1  access strobe to the RAM
- ram_rw  out  1  1 = write
- ram_addr  out  ADDR_W  cell-select address
- ram_wdata  out  DATA_W  write data to the RAM
- ram_rdata  in  DATA_W  combinational read data from the RAM

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so requester 0 wins the first contest.
  - All outputs 0: readies, resp valids/rdata, ram_en, ram_rw, ram_addr, ram_wdata.
- IDLE:
  - grant0 = req0_valid & (~req1_valid | last_grant==1); grant1 = req1_valid & ~grant0.
  - reqN_ready = grant N, combinational, only in IDLE.
  - On handshake (valid & ready): latch rw/addr/wdata and owner id; last_grant <= owner; go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_en=1; ram_rw, ram_addr, ram_wdata driven from the latched values (registered outputs, stable the whole cycle).
  - Write commits at the closing edge.
  - For a read, ram_rdata is sampled into the resp register at the closing edge.
  - Go to RESP.
- RESP (1 cycle):
  - resp<owner>_valid=1; resp<owner>_rdata = captured data for reads, 0 for writes.
  - Other requester's resp outputs stay 0.
  - Return to IDLE.
- Throughput: at most one transaction per 3 cycles. Latency from handshake edge: ram_en high the next cycle, resp_valid the cycle after that.
- Requester rules:
  - Hold valid and payload stable until ready.
  - Payload changes while valid & ~ready are ignored; the arbiter samples only at handshake.
- Both valid continuously: grants alternate 0,1,0,1...
- Single requester valid continuously: it wins every contest; no idle bubble beyond the FSM's 3-cycle period.
- Outside ACCESS: ram_en=0, ram_rw=0; ram_addr and ram_wdata hold their last values.
- Reset asserted mid-ACCESS:
  - ram_en drops immediately (async).
  - The write must not be treated as committed; no response is issued and the transaction is lost.
  - After release, the FSM is in IDLE and requester 0 has priority.
- Address wrap: addr is ADDR_W bits wide; no range checking.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 8 bits, each counting handshakes for its requester.
  - Counters saturate at 255 and reset to 0 asynchronously.
  - A count increments on the handshake edge.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset release, req0 write addr=2 wdata=0xA5:
  - req0_ready=1 in cycle 0.
  - Next cycle: ram_en=1, ram_rw=1, ram_addr=2, ram_wdata=0xA5.
  - Next cycle: resp0_valid=1, resp0_rdata=0.
- req1 read addr=2 after the above, with the RAM model holding 0xA5: ram_en=1, ram_rw=0, ram_addr=2, then resp1_valid=1 with resp1_rdata=0xA5; resp0_valid stays 0.
- Both valid from reset (req0 write addr0 0x11, req1 write addr1 0x22): req0 granted first, req1 granted 3 cycles later; a third contest grants req0.
- req0 valid continuously for 4 transactions, req1 idle: handshakes at cycles 0, 3, 6, 9; each is followed by ram_en one cycle later.
- rst_n pulsed low during ACCESS of a write addr=3 0xFF: ram_en drops asynchronously, no resp0_valid; after release, a read of addr=3 returns the RAM's prior contents.
- With RAM_ARB_STATS_EN: 300 req0 handshakes -> grant_cnt0=255, grant_cnt1=0; reset returns both to 0.
